// File: rtl/my_bus_tx_sequencer.sv
// Serial frame sequencer: collect WIDTH bits, pulse execute,
// wait EXEC_GAP cycles, then replay the frame LSB first.
module my_bus_tx_sequencer #(
  parameter int WIDTH    = 8,
  parameter int EXEC_GAP = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ready,
  input  logic       dataReady,
  input  logic       dataIn,
  output logic       execute,
  output logic       dataTx,
  output logic       busy,
  output logic       overrun,
  output logic [7:0] frameCnt
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int GW = (EXEC_GAP > 0) ? $clog2(EXEC_GAP + 1) : 1;
  localparam int GL = (EXEC_GAP > 0) ? EXEC_GAP - 1 : 0;

  localparam logic [CW-1:0] BLAST = CW'(WIDTH - 1);
  localparam logic [GW-1:0] GLAST = GW'(GL);

  typedef enum logic [2:0] {
    IDLE, COLLECT, EXEC, GAP, SHIFT
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shin;
  logic [CW-1:0]    bcnt;
  logic [GW-1:0]    gcnt;
  logic             take;

  assign take = ready & dataReady;

  // new bits enter at the top so bit 0 ends up holding the first one
  assign shin = (shreg >> 1) | (WIDTH'(dataIn) << (WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      shreg    <= '0;
      bcnt     <= '0;
      gcnt     <= '0;
      overrun  <= 1'b0;
      frameCnt <= 8'd0;
    end else begin
      state <= state_n;
      unique case (state)
        IDLE: begin
          if (take) begin
            shreg <= shin;
            bcnt  <= CW'(1);
          end
        end
        COLLECT: begin
          if (!ready) begin
            bcnt <= '0;
          end else if (dataReady) begin
            shreg <= shin;
            bcnt  <= bcnt + CW'(1);
          end
        end
        EXEC: begin
          bcnt <= '0;
          gcnt <= '0;
        end
        GAP: gcnt <= gcnt + GW'(1);
        SHIFT: begin
          shreg <= shreg >> 1;
          if (bcnt == BLAST) bcnt <= '0;
          else bcnt <= bcnt + CW'(1);
        end
        default: bcnt <= '0;
      endcase
      if (dataReady && (state == EXEC ||
          state == GAP || state == SHIFT))
        overrun <= 1'b1;
      if (state_n == EXEC)
        frameCnt <= frameCnt + 8'd1;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (take)
          state_n = (WIDTH == 1) ? EXEC : COLLECT;
      end
      COLLECT: begin
        if (!ready)
          state_n = IDLE;
        else if (dataReady && bcnt == BLAST)
          state_n = EXEC;
      end
      EXEC:
        state_n = (EXEC_GAP == 0) ? SHIFT : GAP;
      GAP: begin
        if (gcnt == GLAST) state_n = SHIFT;
      end
      SHIFT: begin
        if (bcnt == BLAST) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    execute = 1'b0;
    dataTx  = 1'b0;
    busy    = 1'b0;
    unique case (state)
      IDLE:    busy = 1'b0;
      COLLECT: busy = 1'b1;
      EXEC: begin
        busy    = 1'b1;
        execute = 1'b1;
      end
      GAP:     busy = 1'b1;
      SHIFT: begin
        busy   = 1'b1;
        dataTx = shreg[0];
      end
      default: busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_my_bus_tx_sequencer.sv
// Bench for my_bus_tx_sequencer: two instances (gap 2 and gap 0)
// checked each cycle against a frame-timing reference model.
module tb_my_bus_tx_sequencer;

  localparam int W  = 8;
  localparam int G0 = 2;

  logic       clk;
  logic       rst;
  logic       ready;
  logic       dataReady;
  logic       dataIn;
  logic       execute0, dataTx0, busy0, overrun0;
  logic       execute1, dataTx1, busy1, overrun1;
  logic [7:0] frameCnt0, frameCnt1;

  my_bus_tx_sequencer #(.WIDTH(W), .EXEC_GAP(G0)) dut (
    .clk(clk), .rst(rst), .ready(ready),
    .dataReady(dataReady), .dataIn(dataIn),
    .execute(execute0), .dataTx(dataTx0), .busy(busy0),
    .overrun(overrun0), .frameCnt(frameCnt0)
  );

  my_bus_tx_sequencer #(.WIDTH(W), .EXEC_GAP(0)) dut0 (
    .clk(clk), .rst(rst), .ready(ready),
    .dataReady(dataReady), .dataIn(dataIn),
    .execute(execute1), .dataTx(dataTx1), .busy(busy1),
    .overrun(overrun1), .frameCnt(frameCnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchk = 0;
  int npass = 0;
  int nfail = 0;
  int cyc = 0;

  // model: m_t = edge at which the last frame completed
  int         m_t   [2];
  int         m_cnt [2];
  int         m_fc  [2];
  bit         m_ovr [2];
  logic [7:0] m_bits[2];
  logic [7:0] m_frm [2];

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic mdl(input int k, input int g,
                     input bit r, input bit rd,
                     input bit dr, input bit din);
    bit act;
    if (r) begin
      m_t[k] = -1000; m_cnt[k] = 0;
      m_fc[k] = 0; m_ovr[k] = 0;
    end else begin
      act = cyc > m_t[k] && cyc <= m_t[k] + g + W + 1;
      if (act) begin
        if (dr) m_ovr[k] = 1;
      end else if (m_cnt[k] > 0 && !rd) begin
        m_cnt[k] = 0;
      end else if (rd && dr) begin
        m_bits[k][m_cnt[k]] = din;
        m_cnt[k]++;
        if (m_cnt[k] == W) begin
          m_t[k] = cyc;
          m_frm[k] = m_bits[k];
          m_fc[k] = (m_fc[k] + 1) % 256;
          m_cnt[k] = 0;
        end
      end
    end
  endtask

  task automatic cmp(input int k, input int g,
                     input logic ex, input logic tx,
                     input logic bs, input logic ov,
                     input logic [7:0] fc);
    bit post;
    bit e_ex, e_tx, e_bs;
    int t;
    t = m_t[k];
    post = cyc >= t && cyc <= t + g + W;
    e_ex = post && cyc == t;
    e_bs = post || m_cnt[k] > 0;
    e_tx = 0;
    if (post && cyc >= t + 1 + g)
      e_tx = m_frm[k][cyc - t - 1 - g];
    chk($sformatf("d%0d_exec c%0d", k, cyc), 8'(ex), 8'(e_ex));
    chk($sformatf("d%0d_tx c%0d", k, cyc), 8'(tx), 8'(e_tx));
    chk($sformatf("d%0d_busy c%0d", k, cyc), 8'(bs), 8'(e_bs));
    chk($sformatf("d%0d_ovr c%0d", k, cyc), 8'(ov), 8'(m_ovr[k]));
    chk($sformatf("d%0d_fc c%0d", k, cyc), fc, 8'(m_fc[k]));
  endtask

  task automatic step(input bit r, input bit rd,
                      input bit dr, input bit din);
    rst = r; ready = rd; dataReady = dr; dataIn = din;
    @(posedge clk);
    cyc++;
    mdl(0, G0, r, rd, dr, din);
    mdl(1, 0, r, rd, dr, din);
    #1;
    cmp(0, G0, execute0, dataTx0, busy0, overrun0, frameCnt0);
    cmp(1, 0, execute1, dataTx1, busy1, overrun1, frameCnt1);
  endtask

  task automatic frame_rx(input logic [7:0] v,
                          output logic [7:0] rx,
                          output logic [7:0] rx1,
                          output int ex, output int bsy);
    ex = 0; bsy = 0; rx = '0; rx1 = '0;
    for (int i = 0; i < W; i++) begin
      step(0, 1, 1, v[i]);
      bsy += int'(busy0);
    end
    ex += int'(execute0);
    for (int j = 1; j <= 12; j++) begin
      step(0, 1, 0, 1'($urandom));
      bsy += int'(busy0);
      ex += int'(execute0);
      if (j >= 3 && j <= 10) rx[j-3] = dataTx0;
      if (j <= 8) rx1[j-1] = dataTx1;
    end
  endtask

  logic [7:0] v, rx, rx1;
  int ex, bsy;

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_t[k] = -1000; m_cnt[k] = 0; m_fc[k] = 0;
      m_ovr[k] = 0; m_bits[k] = '0; m_frm[k] = '0;
    end
    rst = 1; ready = 0; dataReady = 0; dataIn = 0;

    // reset with random inputs
    repeat (2) step(1, 1'($urandom), 1'($urandom), 1'($urandom));
    chk("rst_busy", 8'(busy0), 8'd0);
    chk("rst_fc", frameCnt0, 8'd0);

    // basic frame 0xA5
    frame_rx(8'hA5, rx, rx1, ex, bsy);
    chk("a5_rx", rx, 8'hA5);
    chk("a5_rx_gap0", rx1, 8'hA5);
    chk("a5_exec", 8'(ex), 8'd1);
    chk("a5_busy_len", 8'(bsy), 8'd18);
    chk("a5_fc", frameCnt0, 8'd1);

    // abort after 5 bits
    for (int i = 0; i < 5; i++) step(0, 1, 1, 1'($urandom));
    step(0, 0, 0, 0);
    chk("abort_busy", 8'(busy0), 8'd0);
    chk("abort_ovr", 8'(overrun0), 8'd0);
    frame_rx(8'h3C, rx, rx1, ex, bsy);
    chk("3c_rx", rx, 8'h3C);
    chk("3c_exec", 8'(ex), 8'd1);
    chk("3c_fc", frameCnt0, 8'd2);

    // overrun in GAP and in the last SHIFT cycle
    v = 8'($urandom);
    for (int i = 0; i < W; i++) step(0, 1, 1, v[i]);
    rx = '0;
    for (int j = 1; j <= 12; j++) begin
      step(0, 1, j == 2 || j == 11 || j == 12, 1'b1);
      if (j >= 3 && j <= 10) rx[j-3] = dataTx0;
    end
    chk("ovr_set", 8'(overrun0), 8'd1);
    chk("ovr_rx", rx, v);
    chk("ovr_newbusy", 8'(busy0), 8'd1);
    for (int i = 1; i < W; i++) step(0, 1, 1, 1'b1);
    repeat (12) step(0, 1, 0, 1'b0);
    chk("ovr_sticky", 8'(overrun0), 8'd1);
    chk("ovr_fc", frameCnt0, 8'd4);

    // random traffic
    for (int i = 0; i < 400; i++)
      step(0, $urandom_range(0, 9) != 0,
           1'($urandom), 1'($urandom));

    // wrap frameCnt after 256 frames
    step(1, 0, 0, 0);
    for (int f = 0; f < 256; f++) begin
      v = 8'($urandom);
      frame_rx(v, rx, rx1, ex, bsy);
      chk($sformatf("wrap_rx f%0d", f), rx, v);
      chk($sformatf("wrap_rx0 f%0d", f), rx1, v);
    end
    chk("wrap_fc", frameCnt0, 8'd0);
    chk("wrap_fc_gap0", frameCnt1, 8'd0);

    // reset on the 4th shift bit
    v = 8'($urandom);
    for (int i = 0; i < W; i++) step(0, 1, 1, v[i]);
    for (int j = 1; j <= 6; j++) step(0, 1, 0, 1'b0);
    step(1, 1, 1, 1'b1);
    chk("mid_tx", 8'(dataTx0), 8'd0);
    chk("mid_fc", frameCnt0, 8'd0);
    chk("mid_busy", 8'(busy0), 8'd0);
    v = 8'($urandom);
    frame_rx(v, rx, rx1, ex, bsy);
    chk("mid_next_rx", rx, v);
    chk("mid_next_fc", frameCnt0, 8'd1);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
